// File: rtl/axi_master.sv
// axi_master: single-outstanding AXI4 master. It turns user commands into INCR
// bursts on AW/W/B or AR/R, forwards the user write stream onto W, and forwards
// read beats to the user read port. Each transaction ends with a one-cycle done pulse.
module axi_master #(
   parameter int addr_width = 32,
   parameter int data_width = 32,
   parameter int id_width   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   // command
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [addr_width-1:0]   cmd_addr,
   input  logic [7:0]              cmd_len,
   input  logic [id_width-1:0]     cmd_id,
   // user write stream
   input  logic [data_width-1:0]   wr_data,
   input  logic [data_width/8-1:0] wr_strb,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   // user read stream
   output logic [data_width-1:0]   rd_data,
   output logic                    rd_last,
   output logic [1:0]              rd_resp,
   output logic                    rd_valid,
   // completion
   output logic                    done,
   output logic [1:0]              done_resp,
   output logic                    done_err,
   // AW
   output logic [id_width-1:0]     awid,
   output logic [addr_width-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   // W
   output logic [data_width-1:0]   wdata,
   output logic [data_width/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   // B
   input  logic [id_width-1:0]     bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   // AR
   output logic [id_width-1:0]     arid,
   output logic [addr_width-1:0]   araddr,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   // R
   input  logic [data_width-1:0]   rdata,
   input  logic [id_width-1:0]     rid,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready
);

   localparam int unsigned STRB_W = data_width / 8;
   localparam int unsigned SIZE   = $clog2(STRB_W);
   localparam logic [addr_width-1:0] ALIGN_MASK = ~addr_width'(STRB_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_AW, S_W, S_B, S_AR, S_R
   } state_t;

   state_t                 state_q, state_d;
   logic                   run_q;
   logic [addr_width-1:0]  addr_q;
   logic [7:0]             len_q;
   logic [id_width-1:0]    id_q;
   logic [2:0]             size_q;
   logic [1:0]             burst_q;
   logic [7:0]             beat_q;
   logic                   done_q;
   logic [1:0]             resp_q;
   logic                   err_q;
   logic [data_width-1:0]  rd_data_q;
   logic                   rd_last_q;
   logic [1:0]             rd_resp_q;
   logic                   rd_valid_q;

   logic                   last_beat;
   logic                   cmd_hs, w_hs, b_hs, r_hs;

   assign last_beat = (beat_q == len_q);
   assign cmd_hs    = (state_q == S_IDLE) && run_q && cmd_valid;
   assign w_hs      = (state_q == S_W) && wr_valid && wready;
   assign b_hs      = (state_q == S_B) && bvalid;
   assign r_hs      = (state_q == S_R) && rvalid;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // run_q keeps cmd_ready low while in reset and raises it at the first edge after release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) run_q <= 1'b0;
      else      run_q <= 1'b1;
   end

   // next-state decode and combinational channel controls
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      awvalid   = 1'b0;
      arvalid   = 1'b0;
      wvalid    = 1'b0;
      wdata     = '0;
      wstrb     = '0;
      wlast     = 1'b0;
      wr_ready  = 1'b0;
      bready    = 1'b0;
      rready    = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_ready = run_q;
            if (cmd_hs) state_d = cmd_write ? S_AW : S_AR;
         end
         S_AW: begin
            awvalid = 1'b1;
            if (awready) state_d = S_W;
         end
         S_W: begin
            wvalid   = wr_valid;
            wdata    = wr_data;
            wstrb    = wr_strb;
            wlast    = last_beat;
            wr_ready = wready;
            if (w_hs && last_beat) state_d = S_B;
         end
         S_B: begin
            bready = 1'b1;
            if (bvalid) state_d = S_IDLE;
         end
         S_AR: begin
            arvalid = 1'b1;
            if (arready) state_d = S_R;
         end
         S_R: begin
            rready = 1'b1;
            if (rvalid && rlast) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // command latch; address/len/id stay on the bus until the next command
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         len_q   <= '0;
         id_q    <= '0;
         size_q  <= '0;
         burst_q <= '0;
      end else if (cmd_hs) begin
         addr_q  <= cmd_addr & ALIGN_MASK;
         len_q   <= cmd_len;
         id_q    <= cmd_id;
         size_q  <= 3'(SIZE);
         burst_q <= 2'b01;
      end
   end

   // beat counter shared by W and R
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)              beat_q <= '0;
      else if (cmd_hs)       beat_q <= '0;
      else if (w_hs || r_hs) beat_q <= beat_q + 8'd1;
   end

   // completion pulse, final response and protocol-error tracking
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q <= 1'b0;
         resp_q <= '0;
         err_q  <= 1'b0;
      end else begin
         done_q <= b_hs || (r_hs && rlast);
         if (cmd_hs) begin
            resp_q <= '0;
            err_q  <= 1'b0;
         end else if (b_hs) begin
            resp_q <= bresp;
            if (bid != id_q) err_q <= 1'b1;
         end else if (r_hs) begin
            if (resp_q == 2'b00 && rresp != 2'b00) resp_q <= rresp;
            if ((rid != id_q) || (rlast && !last_beat) || (!rlast && last_beat))
               err_q <= 1'b1;
         end
      end
   end

   // registered user read-beat stream; rd_valid pulses for one cycle per beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q  <= '0;
         rd_last_q  <= 1'b0;
         rd_resp_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= r_hs;
         if (r_hs) begin
            rd_data_q <= rdata;
            rd_last_q <= rlast;
            rd_resp_q <= rresp;
         end
      end
   end

   assign awid      = id_q;
   assign awaddr    = addr_q;
   assign awlen     = len_q;
   assign awsize    = size_q;
   assign awburst   = burst_q;
   assign arid      = id_q;
   assign araddr    = addr_q;
   assign arlen     = len_q;
   assign arsize    = size_q;
   assign arburst   = burst_q;
   assign done      = done_q;
   assign done_resp = resp_q;
   assign done_err  = err_q;
   assign rd_data   = rd_data_q;
   assign rd_last   = rd_last_q;
   assign rd_resp   = rd_resp_q;
   assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_axi_master.sv
// tb_axi_master: directed bench for axi_master with an inline slave model.
module tb_axi_master;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [7:0]    cmd_len = '0;
   logic [IW-1:0] cmd_id = '0;
   logic [DW-1:0] wr_data = '0;
   logic [3:0]    wr_strb = '0;
   logic          wr_valid = 1'b0, wr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_last, rd_valid;
   logic [1:0]    rd_resp;
   logic          done, done_err;
   logic [1:0]    done_resp;
   logic [IW-1:0] awid, arid;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic [2:0]    awsize, arsize;
   logic [1:0]    awburst, arburst;
   logic          awvalid, arvalid;
   logic          awready = 1'b0, arready = 1'b0;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic          wlast, wvalid;
   logic          wready = 1'b1;
   logic [IW-1:0] bid = '0;
   logic [1:0]    bresp = '0;
   logic          bvalid = 1'b0, bready;
   logic [DW-1:0] rdata = '0;
   logic [IW-1:0] rid = '0;
   logic [1:0]    rresp = '0;
   logic          rlast = 1'b0, rvalid = 1'b0, rready;

   logic [DW-1:0] mem [0:15];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   axi_master #(.addr_width(AW), .data_width(DW), .id_width(IW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_resp(rd_resp), .rd_valid(rd_valid),
      .done(done), .done_resp(done_resp), .done_err(done_err),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // all tasks enter and leave 1 time unit after a rising edge
   task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [7:0] l,
                            input logic [IW-1:0] id);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
      #1 check("cmd_ready_idle", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("cmd_ready_busy", cmd_ready, 0);
   endtask

   task automatic aw_phase(input int stall, input logic [AW-1:0] ea, input logic [7:0] el,
                           input logic [IW-1:0] eid);
      for (int i = 0; i <= stall; i++) begin
         check("aw_valid", awvalid, 1);
         check("aw_payload", {awaddr, awlen, awsize, awburst, awid},
               {ea, el, 3'd2, 2'b01, eid});
         if (i < stall) begin @(posedge clk); #1; end
      end
      awready = 1'b1;
      @(posedge clk); #1;
      awready = 1'b0;
      check("aw_dropped", awvalid, 0);
   endtask

   task automatic w_phase(input int n, input int gap_at);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            wr_valid = 1'b0;
            #1 check("w_gap_wvalid", wvalid, 0);
            @(posedge clk); #1;
         end
         wr_valid = 1'b1; wr_data = 32'h11 * (i + 1); wr_strb = 4'hf;
         #1;
         check("w_valid", {wvalid, wr_ready}, 2'b11);
         check("w_data", {wdata, wstrb}, {32'h11 * (i + 1), 4'hf});
         check("w_last", wlast, (i == n - 1));
         mem[i] = wdata;
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      check("b_ready", {bready, wvalid, done}, 3'b100);
   endtask

   task automatic b_phase(input logic [IW-1:0] b_id, input logic [1:0] b_resp,
                          input logic exp_err, input logic [1:0] exp_resp);
      bvalid = 1'b1; bid = b_id; bresp = b_resp;
      @(posedge clk); #1;
      bvalid = 1'b0;
      check("b_done", {done, cmd_ready, bready}, 3'b110);
      check("b_done_err", done_err, exp_err);
      check("b_done_resp", done_resp, exp_resp);
      @(posedge clk); #1;
      check("b_done_pulse", done, 0);
   endtask

   task automatic ar_phase(input logic [AW-1:0] ea, input logic [7:0] el,
                           input logic [IW-1:0] eid);
      check("ar_valid", arvalid, 1);
      check("ar_payload", {araddr, arlen, arsize, arburst, arid},
            {ea, el, 3'd2, 2'b01, eid});
      arready = 1'b1;
      @(posedge clk); #1;
      arready = 1'b0;
      check("r_ready", {arvalid, rready}, 2'b01);
   endtask

   task automatic r_phase(input int last_idx, input int bad_idx, input logic [1:0] bad_resp,
                          input logic [IW-1:0] r_id, input bit chk_data,
                          input logic exp_err, input logic [1:0] exp_resp);
      logic [1:0] er;
      for (int i = 0; i <= last_idx; i++) begin
         er = (i == bad_idx) ? bad_resp : ((i > bad_idx) ? 2'b11 : 2'b00);
         rvalid = 1'b1; rid = r_id; rlast = (i == last_idx); rresp = er;
         rdata = mem[i];
         @(posedge clk); #1;
         rvalid = 1'b0; rlast = 1'b0;
         check("rd_valid", rd_valid, 1);
         if (chk_data) check("rd_data", rd_data, 32'h11 * (i + 1));
         check("rd_resp", rd_resp, er);
         check("rd_last", rd_last, (i == last_idx));
         check("r_done", done, (i == last_idx));
      end
      check("r_done_err", done_err, exp_err);
      check("r_done_resp", done_resp, exp_resp);
      check("r_idle", {cmd_ready, rready}, 2'b10);
      @(posedge clk); #1;
      check("r_pulse_end", {done, rd_valid}, 2'b00);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, wlast, done, done_err,
                         rd_valid, rd_last, cmd_ready, wr_ready}, 0);
      check("rst_aw", {awaddr, awlen, awsize, awburst, awid}, 0);
      check("rst_ar", {araddr, arlen, arsize, arburst, arid}, 0);
      check("rst_data", {rd_data, rd_resp, done_resp, wdata}, 0);
      rst = 1'b1;
      #1 check("rst_release_ready", cmd_ready, 0);
      @(posedge clk); #1;
      check("ready_after_rst", cmd_ready, 1);

      // write burst with stalled AW and a wr_valid gap
      issue_cmd(1'b1, 32'h10, 8'd3, 4'd5);
      aw_phase(5, 32'h10, 8'd3, 4'd5);
      w_phase(4, 2);
      b_phase(4'd5, 2'b00, 1'b0, 2'b00);

      // read back the same burst
      issue_cmd(1'b0, 32'h10, 8'd3, 4'd5);
      ar_phase(32'h10, 8'd3, 4'd5);
      r_phase(3, 99, 2'b00, 4'd5, 1'b1, 1'b0, 2'b00);

      // unaligned single-beat write
      issue_cmd(1'b1, 32'h13, 8'd0, 4'd2);
      aw_phase(0, 32'h10, 8'd0, 4'd2);
      w_phase(1, 99);
      b_phase(4'd2, 2'b00, 1'b0, 2'b00);

      // wrong bid, SLVERR response
      issue_cmd(1'b1, 32'h20, 8'd0, 4'd5);
      aw_phase(1, 32'h20, 8'd0, 4'd5);
      w_phase(1, 99);
      b_phase(4'd6, 2'b10, 1'b1, 2'b10);

      // early rlast on beat 1 of len 3
      issue_cmd(1'b0, 32'h40, 8'd3, 4'd5);
      ar_phase(32'h40, 8'd3, 4'd5);
      r_phase(1, 99, 2'b00, 4'd5, 1'b0, 1'b1, 2'b00);

      // SLVERR on beat 2, then DECERR: first non-OKAY response kept
      issue_cmd(1'b0, 32'h44, 8'd3, 4'd7);
      ar_phase(32'h44, 8'd3, 4'd7);
      r_phase(3, 2, 2'b10, 4'd7, 1'b0, 1'b0, 2'b10);

      // rlast late: one extra beat past len
      issue_cmd(1'b0, 32'h80, 8'd1, 4'd3);
      ar_phase(32'h80, 8'd1, 4'd3);
      r_phase(2, 99, 2'b00, 4'd3, 1'b0, 1'b1, 2'b00);

      // wrong rid
      issue_cmd(1'b0, 32'h84, 8'd0, 4'd5);
      ar_phase(32'h84, 8'd0, 4'd5);
      r_phase(0, 99, 2'b00, 4'd4, 1'b0, 1'b1, 2'b00);

      // reset in the middle of a write burst
      issue_cmd(1'b1, 32'h30, 8'd3, 4'd1);
      aw_phase(0, 32'h30, 8'd3, 4'd1);
      wr_valid = 1'b1; wr_data = 32'hdead; wr_strb = 4'hf;
      @(posedge clk); #1;
      #1 check("midw_wvalid", {wvalid, wlast}, 2'b10);
      rst = 1'b0;
      #1;
      check("midw_rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, wlast, done,
                              rd_valid, cmd_ready, wr_ready}, 0);
      check("midw_rst_aw", {awaddr, awlen}, 0);
      wr_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("midw_no_done", {done, cmd_ready, wvalid}, 3'b010);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // absolute time limit
   initial begin
      #200000;
      $display("FAIL timeout: got 0x0 expected 0x1");
      $fatal(1, "timeout");
   end

endmodule
